// File: rtl/freelist_nway_pkg.sv
// Shared free-list definitions: default geometry, pointer type, alloc packet and branch-stack field.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package freelist_nway_pkg;

    localparam int FL_DEPTH     = 32;
    localparam int FL_WAYS      = 3;
    localparam int FL_PREG_W    = 6;
    localparam int FL_PREG_BASE = 32;
    localparam int FL_PTR_W     = $clog2(FL_DEPTH);
    localparam int FL_CNT_W     = $clog2(FL_WAYS + 1);

    // Read/write pointer with a wrap bit above the slot index.
    typedef logic [FL_PTR_W:0]    fl_ptr_t;
    typedef logic [FL_PREG_W-1:0] preg_t;

    typedef struct packed {
        preg_t preg;
        logic  valid;
    } fl_alloc_lane_t;

    typedef fl_alloc_lane_t [FL_WAYS-1:0] fl_alloc_packet_t;

    // Branch-stack field: only the read pointer is snapshotted, not the array.
    typedef struct packed {
        fl_ptr_t fl_read_ptr;
    } fl_br_ckpt_t;

endpackage

// File: rtl/freelist_nway_if.sv
// Free-list port bundle: retire-side frees, rename-side offers/consumption, checkpoint and error flags.
// Latency: n/a (wires only).
// Backpressure: none; rename gates itself with the alloc_valid thermometer.
// master = rename/retire driver, slave = free list.
interface freelist_nway_if
    import freelist_nway_pkg::*;
#(
    parameter int WAYS   = FL_WAYS,
    parameter int PREG_W = FL_PREG_W,
    parameter int PTR_W  = FL_PTR_W,
    parameter int CNT_W  = FL_CNT_W
);
    logic [WAYS-1:0]        free_valid;
    logic [WAYS*PREG_W-1:0] free_preg;
    logic [CNT_W-1:0]       alloc_num;
    logic                   squash;
    logic [PTR_W:0]         restore_read_ptr;
    logic [WAYS*PREG_W-1:0] alloc_preg;
    logic [WAYS-1:0]        alloc_valid;
    logic [PTR_W:0]         free_count;
    logic [PTR_W:0]         ckpt_read_ptr;
    logic                   err_underflow;
    logic                   err_overflow;

    modport master (
        output free_valid, free_preg, alloc_num, squash, restore_read_ptr,
        input  alloc_preg, alloc_valid, free_count, ckpt_read_ptr, err_underflow, err_overflow
    );

    modport slave (
        input  free_valid, free_preg, alloc_num, squash, restore_read_ptr,
        output alloc_preg, alloc_valid, free_count, ckpt_read_ptr, err_underflow, err_overflow
    );
endinterface

// File: rtl/freelist_nway_compact.sv
// Lane packer: popcount of lane_valid plus prefix-sum compaction of valid lanes into the low slots.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: lane_valid/lane_preg in (WAYS lanes), packed_preg out (lane order kept), packed_num out (popcount).
module freelist_nway_compact #(
    parameter int WAYS   = 3,
    parameter int PREG_W = 6,
    parameter int CNT_W  = $clog2(WAYS + 1)
) (
    input  logic [WAYS-1:0]        lane_valid,
    input  logic [WAYS*PREG_W-1:0] lane_preg,
    output logic [WAYS*PREG_W-1:0] packed_preg,
    output logic [CNT_W-1:0]       packed_num
);

    // pos is the running prefix sum: the slot the next valid lane lands in.
    always_comb begin
        int pos;
        pos         = 0;
        packed_preg = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (lane_valid[i]) begin
                packed_preg[pos*PREG_W +: PREG_W] = lane_preg[i*PREG_W +: PREG_W];
                pos = pos + 1;
            end
        end
        packed_num = CNT_W'(pos);
    end

endmodule

// File: rtl/freelist_nway.sv
// N-way physical-register free list: circular FIFO of free preg tags between retire and rename, with free bypass.
// Latency: offers are combinational from state and same-cycle frees; pointer/array updates land next cycle.
// Backpressure: none; rename takes at most the thermometer alloc_valid, excess frees are dropped and flagged.
// Ports: clock, reset (sync, active high), fl (slave modport: frees, alloc_num, squash/restore in;
//        alloc_preg/alloc_valid, free_count, ckpt_read_ptr, sticky err_underflow/err_overflow out).
module freelist_nway
    import freelist_nway_pkg::*;
#(
    parameter int DEPTH     = FL_DEPTH,
    parameter int WAYS      = FL_WAYS,
    parameter int PREG_W    = FL_PREG_W,
    parameter int PREG_BASE = FL_PREG_BASE
) (
    input logic           clock,
    input logic           reset,
    freelist_nway_if.slave fl
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(WAYS + 1);
    // count + nfree can reach DEPTH + WAYS, so one extra bit over the pointer.
    localparam int AV_W  = PTR_W + 2;

    typedef logic [PTR_W:0] ptr_t;

    logic [PREG_W-1:0]      mem [DEPTH];
    ptr_t                   read_ptr;
    ptr_t                   write_ptr;
    logic                   err_underflow_q;
    logic                   err_overflow_q;

    ptr_t                   count;
    ptr_t                   write_ptr_next;
    ptr_t                   read_ptr_next;
    ptr_t                   restore_count;
    logic [WAYS*PREG_W-1:0] packed_free;
    logic [CNT_W-1:0]       nfree;
    logic [AV_W-1:0]        avail;
    logic [CNT_W-1:0]       grant;
    logic                   underflow_now;
    logic                   free_drop;
    logic                   restore_bad;
    logic [WAYS*PREG_W-1:0] offer_preg;
    logic [WAYS-1:0]        offer_valid;

    freelist_nway_compact #(
        .WAYS   (WAYS),
        .PREG_W (PREG_W),
        .CNT_W  (CNT_W)
    ) u_compact (
        .lane_valid  (fl.free_valid),
        .lane_preg   (fl.free_preg),
        .packed_preg (packed_free),
        .packed_num  (nfree)
    );

    assign count = write_ptr - read_ptr;
    assign avail = AV_W'(count) + AV_W'(nfree);

    // Offer: lanes below count come from the array, the rest are bypassed from this cycle's packed frees.
    always_comb begin
        offer_preg  = '0;
        offer_valid = '0;
        for (int i = 0; i < WAYS; i++) begin
            offer_valid[i] = (AV_W'(i) < avail);
            if (AV_W'(i) < AV_W'(count)) begin
                offer_preg[i*PREG_W +: PREG_W] = mem[read_ptr[PTR_W-1:0] + PTR_W'(i)];
            end else begin
                offer_preg[i*PREG_W +: PREG_W] = packed_free[(i - int'(count))*PREG_W +: PREG_W];
            end
        end
    end

    // Grant is clipped to what is on offer; a squash cycle consumes nothing.
    always_comb begin
        underflow_now = 1'b0;
        grant         = '0;
        if (!fl.squash) begin
            if (AV_W'(fl.alloc_num) > avail) begin
                underflow_now = 1'b1;
                grant         = CNT_W'(avail);
            end else begin
                grant = fl.alloc_num;
            end
        end
    end

    // Frees that would overfill the array are dropped as a group so no tag is half-written.
    assign free_drop      = (avail > AV_W'(DEPTH));
    assign write_ptr_next = free_drop ? write_ptr : write_ptr + ptr_t'(nfree);

    // A restore is only legal if it leaves no more than DEPTH tags between it and the new tail.
    assign restore_count  = write_ptr_next - fl.restore_read_ptr;
    assign restore_bad    = fl.squash && (restore_count > ptr_t'(DEPTH));

    always_comb begin
        if (fl.squash) begin
            read_ptr_next = restore_bad ? read_ptr : fl.restore_read_ptr;
        end else begin
            read_ptr_next = read_ptr + ptr_t'(grant);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            read_ptr        <= '0;
            write_ptr       <= {1'b1, {PTR_W{1'b0}}};
            err_underflow_q <= 1'b0;
            err_overflow_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PREG_W'(PREG_BASE + i);
            end
        end else begin
            read_ptr  <= read_ptr_next;
            write_ptr <= write_ptr_next;
            if (underflow_now) begin
                err_underflow_q <= 1'b1;
            end
            if (free_drop || restore_bad) begin
                err_overflow_q <= 1'b1;
            end
            // Bypassed tags are written too; the read pointer moves past them in the same cycle.
            if (!free_drop) begin
                for (int j = 0; j < WAYS; j++) begin
                    if (j < int'(nfree)) begin
                        mem[write_ptr[PTR_W-1:0] + PTR_W'(j)] <= packed_free[j*PREG_W +: PREG_W];
                    end
                end
            end
        end
    end

    assign fl.alloc_preg    = offer_preg;
    assign fl.alloc_valid   = offer_valid;
    assign fl.free_count    = count;
    assign fl.ckpt_read_ptr = read_ptr + ptr_t'(grant);
    assign fl.err_underflow = err_underflow_q;
    assign fl.err_overflow  = err_overflow_q;

endmodule

// File: tb/tb_freelist_nway.sv
module tb_freelist_nway;
    import freelist_nway_pkg::*;

    typedef struct {
        logic [2:0]  fv;
        logic [17:0] fp;
        logic [1:0]  an;
        logic        sq;
        logic [5:0]  rr;
        logic [2:0]  ev;
        logic [17:0] ep;
        logic [5:0]  ecnt;
        logic [5:0]  eck;
        logic        euf;
        logic        eof;
    } vec_t;

    logic   clock = 1'b0;
    logic   reset = 1'b1;
    vec_t   vecs[$];
    int     checks = 0;
    int     failures = 0;
    int     uf_e = 0;
    int     of_e = 0;

    freelist_nway_if #(.WAYS(3), .PREG_W(6), .PTR_W(5), .CNT_W(2)) fl ();

    freelist_nway #(.DEPTH(32), .WAYS(3), .PREG_W(6), .PREG_BASE(32)) dut (
        .clock (clock),
        .reset (reset),
        .fl    (fl)
    );

    always #5 clock = ~clock;

    task automatic add(input int fv, input int p0, input int p1, input int p2, input int an,
                       input int sq, input int rr, input int ev, input int e0, input int e1,
                       input int e2, input int ecnt, input int eck);
        vec_t v;
        v.fv   = 3'(fv);
        v.fp   = {6'(p2), 6'(p1), 6'(p0)};
        v.an   = 2'(an);
        v.sq   = 1'(sq);
        v.rr   = 6'(rr);
        v.ev   = 3'(ev);
        v.ep   = {6'(e2), 6'(e1), 6'(e0)};
        v.ecnt = 6'(ecnt);
        v.eck  = 6'(eck);
        v.euf  = 1'(uf_e);
        v.eof  = 1'(of_e);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%0d expected=%0d", name, idx, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] fv, input logic [17:0] fp, input logic [1:0] an,
                         input logic sq, input logic [5:0] rr);
        fl.free_valid       = fv;
        fl.free_preg        = fp;
        fl.alloc_num        = an;
        fl.squash           = sq;
        fl.restore_read_ptr = rr;
    endtask

    task automatic check_outputs(input int idx, input vec_t v);
        check("free_count", idx, int'(fl.free_count), int'(v.ecnt));
        check("alloc_valid", idx, int'(fl.alloc_valid), int'(v.ev));
        check("ckpt_read_ptr", idx, int'(fl.ckpt_read_ptr), int'(v.eck));
        check("err_underflow", idx, int'(fl.err_underflow), int'(v.euf));
        check("err_overflow", idx, int'(fl.err_overflow), int'(v.eof));
        for (int l = 0; l < 3; l++) begin
            if (v.ev[l]) begin
                check($sformatf("alloc_preg%0d", l), idx,
                      int'(fl.alloc_preg[l*6 +: 6]), int'(v.ep[l*6 +: 6]));
            end
        end
    endtask

    // Tag order expected after the squash: array slots from the restored pointer, then the two late frees.
    function automatic int seq2(input int n);
        return (n < 29) ? (3 + n) : (60 + n - 29);
    endfunction

    initial begin
        vec_t v;

        // Reset, idle, then drain all 32 tags.
        add(0, 0, 0, 0, 0, 0, 0, 3'b111, 32, 33, 34, 32, 0);
        for (int k = 0; k < 10; k++) begin
            add(0, 0, 0, 0, 3, 0, 0, 3'b111, 32 + 3*k, 33 + 3*k, 34 + 3*k, 32 - 3*k, 3*k + 3);
        end
        add(0, 0, 0, 0, 2, 0, 0, 3'b011, 62, 63, 0, 2, 32);
        add(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 32);
        // Bypass with a hole in lane 1.
        add(3'b101, 7, 20, 9, 2, 0, 0, 3'b011, 7, 9, 0, 0, 34);
        add(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 34);
        // Underflow: one free, two requested.
        add(3'b010, 0, 11, 0, 2, 0, 0, 3'b001, 11, 0, 0, 0, 35);
        uf_e = 1;
        add(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 35);
        // Refill to full with tags 0..31; the write pointer wraps past slot 31.
        for (int j = 0; j < 10; j++) begin
            add(3'b111, 3*j, 3*j + 1, 3*j + 2, 0, 0, 0, 3'b111, 0, 1, 2, 3*j, 35);
        end
        add(3'b011, 30, 31, 0, 0, 0, 0, 3'b111, 0, 1, 2, 30, 35);
        // Overflow: free into a full list is dropped.
        add(3'b001, 50, 0, 0, 0, 0, 0, 3'b111, 0, 1, 2, 32, 35);
        of_e = 1;
        add(0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 1, 2, 32, 35);
        // Snapshot at 38, allocate 6 more, retire 2, squash back to 38.
        add(0, 0, 0, 0, 3, 0, 0, 3'b111, 0, 1, 2, 32, 38);
        add(0, 0, 0, 0, 3, 0, 0, 3'b111, 3, 4, 5, 29, 41);
        add(0, 0, 0, 0, 3, 0, 0, 3'b111, 6, 7, 8, 26, 44);
        add(3'b011, 60, 61, 0, 0, 0, 0, 3'b111, 9, 10, 11, 23, 44);
        add(0, 0, 0, 0, 3, 1, 38, 3'b111, 9, 10, 11, 25, 44);
        // Drain 31 tags across the read-pointer wrap; late frees sit at the tail.
        for (int k = 0; k < 10; k++) begin
            add(0, 0, 0, 0, 3, 0, 0, 3'b111, seq2(3*k), seq2(3*k + 1), seq2(3*k + 2),
                31 - 3*k, (38 + 3*(k + 1)) % 64);
        end
        add(0, 0, 0, 0, 1, 0, 0, 3'b001, 61, 0, 0, 1, 5);
        add(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 5);

        drive(3'b000, '0, 2'd0, 1'b0, 6'd0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.fv, v.fp, v.an, v.sq, v.rr);
            #1;
            check_outputs(i, v);
            @(negedge clock);
        end

        // Reset wins over a concurrent squash and allocation, and clears the sticky flags.
        drive(3'b111, {6'd1, 6'd2, 6'd3}, 2'd3, 1'b1, 6'd17);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        drive(3'b000, '0, 2'd0, 1'b0, 6'd0);
        #1;
        uf_e = 0;
        of_e = 0;
        v.ev = 3'b111; v.ep = {6'd34, 6'd33, 6'd32}; v.ecnt = 6'd32; v.eck = 6'd0;
        v.euf = 1'b0; v.eof = 1'b0;
        check_outputs(100, v);
        @(negedge clock);

        // Restore that would leave 33 tags live: flagged, read pointer held.
        drive(3'b000, '0, 2'd2, 1'b1, 6'd63);
        #1;
        check("squash_ckpt", 101, int'(fl.ckpt_read_ptr), 0);
        check("squash_err_before", 101, int'(fl.err_overflow), 0);
        @(negedge clock);
        drive(3'b000, '0, 2'd0, 1'b0, 6'd0);
        #1;
        v.eof = 1'b1;
        check_outputs(102, v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
